// File: rtl/serial_adder_rc_pkg.sv
// rtl/serial_adder_rc_pkg.sv - shared state type and reset constants for serial_adder_rc
package serial_adder_rc_pkg;

  // Controller states: IDLE after reset, RUN for one bit per clock, DONE for one cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reset value of the result; bits [31:0] seed sum, bit 32 seeds cout
  localparam logic [32:0] RESULT_RST = '0;

endpackage

// File: rtl/serial_adder_rc_full_adder_cell.sv
// rtl/serial_adder_rc_full_adder_cell.sv - combinational 1-bit full adder cell
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and carry of a single bit position
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_rc.sv
// rtl/serial_adder_rc.sv - bit-serial ripple adder, LSB first; SERIAL_ADDER_RC_SUB_EN adds a subtract mode
module serial_adder_rc
  import serial_adder_rc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_RC_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             sub_q, sub_d;
  logic             sub_in;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_RC_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  full_adder_cell u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next-state and datapath: load on accepted start, one bit per RUN cycle
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is a + ~b + ~cin, so cin acts as borrow-in
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = sub_in ? ~b : b;
          carry_d = sub_in ? ~cin : cin;
          sub_d   = sub_in;
          cnt_d   = '0;
          sum_d   = RESULT_RST[WIDTH-1:0];
          cout_d  = RESULT_RST[32];
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // In subtract mode the borrow-out is the inverted final carry
          state_d = DONE;
          cout_d  = fa_co ^ sub_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= RESULT_RST[WIDTH-1:0];
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= RESULT_RST[32];
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  // Status decoded from the state register only
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_rc.sv
// tb/tb_serial_adder_rc.sv - directed self-checking bench for serial_adder_rc
module tb_serial_adder_rc;

  logic       clk = 1'b0;
  logic       rst_n, start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       sub_v;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  serial_adder_rc #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_RC_SUB_EN
    .sub   (sub_v),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and check latency, busy length, result and hold
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input logic [7:0] esum, input logic ecout);
    int lat;
    int bcnt;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub_v = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy"}, bcnt, 8);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, cout, ecout);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_sum_hold"}, sum, esum);
  endtask

  initial begin
    int dcnt;
    int gap;
    logic [7:0] first_sum;
    logic       first_cout;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    rst_n = 1'b1;

    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

    // start during RUN must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; first_sum = '0; first_cout = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        if (dcnt == 0) begin
          first_sum = sum;
          first_cout = cout;
        end
        dcnt++;
      end
      @(negedge clk);
    end
    chk("ign_done_count", dcnt, 1);
    chk("ign_sum", first_sum, 8'h46);
    chk("ign_cout", first_cout, 1'b0);

    // reset mid-RUN aborts with zeroed outputs
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", sum, 8'h00);
    chk("abort_cout", cout, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op("after_abort", 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);

    // back-to-back with start held high through DONE
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_lat1", gap, 9);
    chk("b2b_sum1", sum, 8'h03);
    chk("b2b_cout1", cout, 1'b0);
    a = 8'h80; b = 8'h80;
    @(negedge clk);
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    chk("b2b_gap", gap, 9);
    chk("b2b_sum2", sum, 8'h00);
    chk("b2b_cout2", cout, 1'b1);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_idle_done", done, 1'b0);

`ifdef SERIAL_ADDER_RC_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    run_op("sub0_add", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_rc.md
# serial_adder_rc

Bit-serial ripple adder, the addition counterpart to the team's full-subtractor cell. It accepts two WIDTH-bit operands plus carry-in on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits beside the subtractor in small datapaths where area matters more than latency.

## Interface
- WIDTH, default 8: operand and sum width; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  augend; captured on accepted start.
- b  in  WIDTH  addend; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result; held from done until the next accepted start.
- cout  out  1  carry-out; held like sum.

## Operation
- States:
  - IDLE: after reset.
  - RUN: bit processing.
  - DONE: one cycle.
- Accepted start (state IDLE or DONE, start=1):
  - load a_sh<=a, b_sh<=b, carry<=cin, bit counter<=0.
  - clear the sum shift register.
  - go to RUN.
- Each RUN cycle:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= a_sh[0]&b_sh[0] | carry&(a_sh[0]^b_sh[0]).
  - s is shifted into the sum register MSB, and the register shifts right.
  - a_sh and b_sh shift right.
  - counter increments.
- When counter reaches WIDTH-1, the RUN cycle processes the last bit and transitions to DONE.
- DONE:
  - done=1, busy=0.
  - sum and cout are valid. cout is the final carry.
  - Next state is IDLE, or RUN if start=1.
- start while in RUN is ignored. Operands are not re-captured and the result is unaffected.
- Counter width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH, and overflow appears only on cout.
- Reset value of every output: busy=0, done=0, sum=0, cout=0. State returns to IDLE.
- Reset asserted mid-RUN aborts immediately. No done is issued, and outputs read zero.
- sum and cout change only during RUN and remain stable in IDLE.

## Timing
- Accepted start at edge E0. RUN covers edges E1..EWIDTH, one bit per edge.
- done is high in the cycle after EWIDTH. Total latency is WIDTH+1 cycles from the start edge to done visible.
- busy is high for exactly WIDTH cycles.
- Back-to-back operation: start held high in DONE gives one result every WIDTH+1 cycles.
- Outputs are driven by registers only, with no combinational path from inputs.

## Configuration
- SERIAL_ADDER_RC_SUB_EN:
  - Defined: adds input port sub (1 bit), captured on accepted start.
    - When sub=1, b is loaded inverted and carry is initialised to ~cin. cin then acts as borrow-in, giving a−b−cin.
    - cout reports borrow-out, which is the inverse of the final carry.
    - When sub=0, the block behaves exactly as an adder.
  - Undefined: no sub port; the block is an adder only.

## Structure
- Shared package serial_adder_rc_pkg holds:
  - the state typedef: IDLE, RUN, DONE.
  - localparam for the reset value of the result.
- Sub-module full_adder_cell: purely combinational 1-bit cell.
  - Inputs: a, b, cin.
  - Outputs: s, co.
  - Instantiated once; the top keeps all state.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, cin=0, start at E0 → done at E9, sum=0x7F, cout=0, busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- Start pulsed at E3 during RUN with different operands → ignored; first result unchanged, single done.
- rst_n low at E4 mid-RUN → busy=0, sum=0, cout=0, no done; fresh start afterwards gives a correct result.
- start held high through DONE, a=0x01, b=0x02 then a=0x80, b=0x80 → results 0x03/cout 0, then 0x00/cout 1, done pulses 9 cycles apart.
- With SERIAL_ADDER_RC_SUB_EN:
  - sub=1, a=0x10, b=0x01, cin=0 → sum=0x0F, cout=0.
  - sub=1, a=0x00, b=0x01, cin=0 → sum=0xFF, cout=1 (borrow).
